// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding and default durations.
package pulse_stretcher_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'b00;
    localparam state_t StOn   = 2'b01;
    localparam state_t StGap  = 2'b10;

    localparam int unsigned DefaultOnCycles  = 100;
    localparam int unsigned DefaultGapCycles = 50;
    localparam int unsigned DefaultTimerBits = 7;
    localparam int unsigned DefaultPendBits  = 3;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Event-in / stretched-level-out signal bundle of the pulse stretcher.
interface pulse_stretcher_if
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned PEND_BITS = DefaultPendBits
);
    logic                 input_pulse;
    logic                 output_stretched;
    logic                 busy;
    logic [PEND_BITS-1:0] pending;
    logic                 overflow;

    modport master (
        output input_pulse,
        input  output_stretched,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  input_pulse,
        output output_stretched,
        output busy,
        output pending,
        output overflow
    );
endinterface

// File: rtl/pulse_stretcher_stretch_timer.sv
// Loadable down-counter that stops at zero and flags it; used to time ON and GAP periods.
module stretch_timer #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);
    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into fixed-length high levels separated by a forced low gap,
// queueing events that arrive while busy in a saturating pending counter.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = DefaultOnCycles,
    parameter int unsigned GAP_CYCLES = DefaultGapCycles,
    parameter int unsigned TIMER_BITS = DefaultTimerBits,
    parameter int unsigned PEND_BITS  = DefaultPendBits
) (
    input  logic               clk,
    input  logic               reset_n,
    pulse_stretcher_if.slave   bus
);
    localparam logic [TIMER_BITS-1:0] OnLoad  = TIMER_BITS'(ON_CYCLES - 1);
    localparam logic [TIMER_BITS-1:0] GapLoad = TIMER_BITS'(GAP_CYCLES - 1);
    localparam logic [PEND_BITS-1:0]  PendMax = '1;

    state_t                state_q, state_d;
    logic [PEND_BITS-1:0]  pending_q, pending_d;
    logic                  out_q, busy_q, ovf_q, ovf_d;
    logic                  timer_load, timer_zero;
    logic [TIMER_BITS-1:0] timer_value;
    logic                  pulse, pend_full;

    assign pulse     = bus.input_pulse;
    assign pend_full = (pending_q == PendMax);

    stretch_timer #(
        .WIDTH (TIMER_BITS)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        ovf_d       = 1'b0;
        timer_load  = 1'b0;
        timer_value = OnLoad;
        case (state_q)
            StIdle: begin
                if (pulse) begin
                    state_d    = StOn;
                    timer_load = 1'b1;
                end
            end
            StOn: begin
                if (pulse) begin
                    if (pend_full) ovf_d = 1'b1;
                    else           pending_d = pending_q + 1'b1;
                end
                if (timer_zero) begin
                    state_d     = StGap;
                    timer_load  = 1'b1;
                    timer_value = GapLoad;
                end
            end
            StGap: begin
                if (timer_zero) begin
                    // A pulse on the last gap cycle restarts directly; it replaces the
                    // decrement so the pending count is left untouched.
                    if (pulse || pending_q != '0) begin
                        state_d    = StOn;
                        timer_load = 1'b1;
                        if (!pulse) pending_d = pending_q - 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (pulse) begin
                    if (pend_full) ovf_d = 1'b1;
                    else           pending_d = pending_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            out_q     <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            out_q     <= (state_d == StOn);
            busy_q    <= (state_d != StIdle);
            ovf_q     <= ovf_d;
        end
    end

    assign bus.output_stretched = out_q;
    assign bus.busy             = busy_q;
    assign bus.pending          = pending_q;
    assign bus.overflow         = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: directed scenarios plus random traffic against a
// schedule-based reference model (period start time + pending count).
module tb_pulse_stretcher;
    localparam int ON   = 4;
    localparam int GAP  = 2;
    localparam int PB   = 2;
    localparam int PMAX = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests_run = 0;
    int   failures = 0;

    // Model: s = edge index at which the current/last high period started (-1 if none).
    longint e = 0;
    longint s = -1;
    int     m_q = 0;
    bit     m_ovf = 1'b0;

    pulse_stretcher_if #(.PEND_BITS(PB)) bus ();

    pulse_stretcher #(
        .ON_CYCLES  (ON),
        .GAP_CYCLES (GAP),
        .TIMER_BITS (7),
        .PEND_BITS  (PB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] obs();
        return {bus.output_stretched, bus.busy, bus.pending, bus.overflow};
    endfunction

    function automatic logic [4:0] expv();
        logic o, b;
        o = (s >= 0) && (e <= s + ON - 1);
        b = (s >= 0) && (e <= s + ON + GAP - 1);
        return {o, b, 2'(m_q), m_ovf};
    endfunction

    task automatic model_reset();
        s = -1;
        m_q = 0;
        m_ovf = 1'b0;
    endtask

    // Drive one cycle of input, advance the model across the edge, settle past the edge.
    task automatic step(input bit p);
        bit busy_before;
        bus.input_pulse = p;
        @(posedge clk);
        e++;
        m_ovf = 1'b0;
        busy_before = (s >= 0) && (e - 1 <= s + ON + GAP - 1);
        if (!busy_before) begin
            if (p) s = e;
        end else if (e - 1 == s + ON + GAP - 1) begin
            if (p || m_q > 0) begin
                s = e;
                if (!p) m_q--;
            end
        end else if (p) begin
            if (m_q < PMAX) m_q++;
            else m_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.input_pulse = 1'b0;
        #3;
        tests_run++;
        if (obs() !== 5'b0) begin
            failures++;
            $display("FAIL reset_hold: got %b want %b", obs(), 5'b0);
        end
        repeat (2) @(posedge clk);
        #4 reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            tests_run++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL reset_idle edge %0d: got %b want %b", e, obs(), expv());
            end
        end
    endtask

    task automatic test_single();
        int hi = 0, bz = 0;
        for (int i = 0; i < 10; i++) begin
            step(i == 0);
            hi += int'(bus.output_stretched);
            bz += int'(bus.busy);
            tests_run++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL single edge %0d: got %b want %b", e, obs(), expv());
            end
        end
        tests_run++;
        if (hi != ON || bz != ON + GAP) begin
            failures++;
            $display("FAIL single_len: got hi=%0d busy=%0d want hi=%0d busy=%0d",
                     hi, bz, ON, ON + GAP);
        end
    endtask

    task automatic test_two();
        int rises = 0;
        logic prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(i == 0 || i == 2);
            if (bus.output_stretched && !prev) rises++;
            prev = bus.output_stretched;
            tests_run++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL two edge %0d: got %b want %b", e, obs(), expv());
            end
        end
        tests_run++;
        if (rises != 2) begin
            failures++;
            $display("FAIL two_periods: got %0d want 2", rises);
        end
    endtask

    task automatic test_saturate();
        int rises = 0, ovfs = 0;
        logic prev = 1'b0;
        for (int i = 0; i < 35; i++) begin
            step(i < 5);
            if (bus.output_stretched && !prev) rises++;
            prev = bus.output_stretched;
            ovfs += int'(bus.overflow);
            tests_run++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL saturate edge %0d: got %b want %b", e, obs(), expv());
            end
        end
        tests_run++;
        if (rises != 4 || ovfs != 1) begin
            failures++;
            $display("FAIL saturate_counts: got periods=%0d ovf=%0d want 4 and 1", rises, ovfs);
        end
    endtask

    task automatic test_gap_end();
        for (int i = 0; i < 6; i++) step(i == 0);
        step(1'b1);  // lands on the last gap cycle of the first period
        tests_run++;
        if (obs() !== 5'b11000) begin
            failures++;
            $display("FAIL gap_end_restart: got %b want %b", obs(), 5'b11000);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            tests_run++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL gap_end edge %0d: got %b want %b", e, obs(), expv());
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1'b1);
        tests_run++;
        if (obs() !== 5'b11100) begin
            failures++;
            $display("FAIL pre_reset: got %b want %b", obs(), 5'b11100);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (obs() !== 5'b0) begin
            failures++;
            $display("FAIL async_reset: got %b want %b", obs(), 5'b0);
        end
        model_reset();
        #1 reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            tests_run++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL post_reset edge %0d: got %b want %b", e, obs(), expv());
            end
        end
    endtask

    task automatic test_held();
        int rises = 0;
        logic prev = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step(i < 3);
            if (bus.output_stretched && !prev) rises++;
            prev = bus.output_stretched;
            tests_run++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL held edge %0d: got %b want %b", e, obs(), expv());
            end
        end
        tests_run++;
        if (rises != 3) begin
            failures++;
            $display("FAIL held_periods: got %0d want 3", rises);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 440; i++) begin
            step(i < 400 && $urandom_range(0, 5) == 0);
            tests_run++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random edge %0d: got %b want %b", e, obs(), expv());
            end
        end
    endtask

    initial begin
        bus.input_pulse = 1'b0;
        test_reset();
        test_single();
        test_two();
        test_saturate();
        test_gap_end();
        test_async_reset();
        test_held();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
Receives single-cycle event pulses, such as the debounced button strobes in the stopwatch, and expands each one into a long, visible high level of fixed length for LED, buzzer or indicator outputs. Consecutive outputs are separated by a mandatory low gap. Events that arrive while an output is active are queued in a saturating pending counter and replayed in order. This block does the inverse of debouncing: short pulse in, long stable level out.

Parameters:
ON_CYCLES, 100, output high duration in clk cycles; legal range 1..2**TIMER_BITS-1
GAP_CYCLES, 50, forced low duration after each high period; legal range 1..2**TIMER_BITS-1
TIMER_BITS, 7, width of the duration timer
PEND_BITS, 3, width of the pending-event counter; saturates at 2**PEND_BITS-1

Ports:
clk  input  1  system clock; all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
input_pulse  input  1  event strobe; every cycle sampled high counts as one event
output_stretched  output  1  stretched level, registered
busy  output  1  registered; high whenever state is not IDLE
pending  output  PEND_BITS  number of queued, not-yet-started events, registered
overflow  output  1  single-cycle pulse when an event is dropped because pending is saturated

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, timer=0, output_stretched=0, busy=0, pending=0, overflow=0. Asserting reset mid-ON or mid-GAP aborts immediately and discards all queued events.
- States: IDLE, ON, GAP.
- IDLE: input_pulse=1 at edge t -> state ON, timer loaded, output_stretched=1 after edge t.
  - Latency is 1 cycle.
  - The output stays high for exactly ON_CYCLES consecutive cycles.
- ON: timer counts down. After the ON_CYCLES-th high cycle -> state GAP, output_stretched=0 for exactly GAP_CYCLES cycles.
- GAP end (last gap cycle):
  - pending>0 -> state ON, pending decremented by 1. The next high period follows with no extra idle cycle.
  - pending==0 -> state IDLE.
- input_pulse=1 while in ON or GAP:
  - pending<max -> pending+1.
  - pending==max -> event dropped, overflow=1 for that one cycle, pending unchanged.
- Simultaneous events at GAP end:
  - pulse with pending==0 -> straight to ON, pending stays 0.
  - pulse with pending>0 -> increment and decrement cancel, pending unchanged, go to ON.
- Simultaneous event at ON end: the pulse is queued normally.
- input_pulse held high for N cycles counts as N events; upstream is expected to drive single-cycle strobes.
- Timer arithmetic:
  - Load value is the duration minus 1; count down to 0.
  - The state transition happens on the cycle the timer reads 0.
  - The timer never wraps.
- pending arithmetic is unsigned and saturating at both ends; it never underflows.
- busy = (state != IDLE). It goes high in the same cycle output_stretched first rises and drops in the cycle the FSM returns to IDLE.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'b00, ON=2'b01, GAP=2'b10; 2'b11 is illegal and recovers to IDLE.
  - default duration constants.
- One natural sub-module, stretch_timer: a loadable down-counter with load value, load strobe and a zero flag, TIMER_BITS wide.
- FSM and pending counter stay in the top level.

Test Plan:
(bench uses ON_CYCLES=4, GAP_CYCLES=2, PEND_BITS=2)
- Single pulse at cycle 10 -> output_stretched high cycles 11-14, low from 15; busy high 11-16, low from 17; pending stays 0.
- Two pulses at cycles 10 and 12 -> pending=1 from cycle 13; high 11-14, low 15-16, high 17-20; pending back to 0 at cycle 17; IDLE at 23.
- Five pulses at cycles 10, 11, 12, 13, 14 -> pending saturates at 3; overflow high only in cycle 15 (the 5th pulse); exactly 4 high periods are produced.
- Pulse exactly on the last GAP cycle with pending=0 -> next high period starts with no idle cycle; pending stays 0.
- reset_n driven low mid-ON with pending=2 -> all outputs 0 immediately, asynchronously; after release, no replay occurs.
- input_pulse held high for 3 cycles starting in IDLE -> first cycle starts ON, pending reaches 2, three high periods are produced.
